// File: rtl/field_pack_pkg.sv
// Shared definitions for the bit-field pack/unpack path.
// Both sides import this package so the field layout is defined in one place.
package field_pack_pkg;

    localparam int DEF_FIELD_W    = 1;
    localparam int DEF_NUM_FIELDS = 3;
    localparam int DEF_MSB_FIRST  = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpack_state_t;

    // A single-field word still needs a one-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int num_fields);
        return (num_fields <= 1) ? 1 : $clog2(num_fields);
    endfunction

endpackage

// File: rtl/field_unpacker_if.sv
// Word-in / field-out handshake bundle for field_unpacker.
interface field_unpacker_if #(
    parameter int FIELD_W    = field_pack_pkg::DEF_FIELD_W,
    parameter int NUM_FIELDS = field_pack_pkg::DEF_NUM_FIELDS
);
    localparam int WORD_W = FIELD_W * NUM_FIELDS;
    localparam int IDX_W  = field_pack_pkg::idx_width(NUM_FIELDS);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [FIELD_W-1:0] out_field;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    // The environment (word source plus field consumer) drives the master side.
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_field, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_field, out_idx, out_last
    );

endinterface

// File: rtl/field_unpacker.sv
// Splits one packed word into NUM_FIELDS fields, emitted one per handshake.
// A new word may be accepted in the same cycle the last field leaves.
module field_unpacker #(
    parameter int FIELD_W    = field_pack_pkg::DEF_FIELD_W,
    parameter int NUM_FIELDS = field_pack_pkg::DEF_NUM_FIELDS,
    parameter int MSB_FIRST  = field_pack_pkg::DEF_MSB_FIRST
) (
    input logic               clk,
    input logic               rst_n,
    field_unpacker_if.slave   bus
);
    import field_pack_pkg::*;

    localparam int WORD_W = FIELD_W * NUM_FIELDS;
    localparam int IDX_W  = idx_width(NUM_FIELDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    unpack_state_t     state, state_nxt;
    logic [WORD_W-1:0] word_q, word_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic              last;
    logic              in_ready;
    logic [FIELD_W-1:0] fields [NUM_FIELDS];
    logic [FIELD_W-1:0] field_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            state  <= state_nxt;
            word_q <= word_nxt;
            idx_q  <= idx_nxt;
        end
    end

    assign last = (idx_q == LAST_IDX);

    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        idx_nxt   = idx_q;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    word_nxt  = bus.in_word;
                    idx_nxt   = '0;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last) begin
                        // Refill on the final handshake so back-to-back words leave no bubble.
                        in_ready = 1'b1;
                        if (bus.in_valid) begin
                            word_nxt = bus.in_word;
                            idx_nxt  = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
        if (MSB_FIRST != 0) begin : g_msb
            assign fields[k] = word_q[WORD_W-1-k*FIELD_W -: FIELD_W];
        end else begin : g_lsb
            assign fields[k] = word_q[k*FIELD_W +: FIELD_W];
        end
    end

    always_comb begin
        field_sel = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx_q == IDX_W'(k)) field_sel = fields[k];
        end
    end

    // Outputs come straight from the held word and index, so they stay put in IDLE and under stall.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == EMIT);
    assign bus.out_field = field_sel;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last;

endmodule
